// File: rtl/mips_mem_pkg.sv
// Shared constants for the MIPS data-memory responder and its timer.
// Holds the MMIO base, timer register offsets, CTRL bit indices and CMP reset value.
package mips_mem_pkg;

    localparam logic [31:0] MMIO_BASE = 32'hFFFF_0000;

    localparam logic [15:0] TIMER_COUNT_OFS = 16'h0000;
    localparam logic [15:0] TIMER_CMP_OFS   = 16'h0004;
    localparam logic [15:0] TIMER_CTRL_OFS  = 16'h0008;
    localparam logic [15:0] TIMER_STAT_OFS  = 16'h000C;

    localparam int EN_BIT      = 0;
    localparam int AUTOCLR_BIT = 1;
    localparam int IRQEN_BIT   = 2;

    localparam logic [31:0] CMP_RESET = 32'hFFFF_FFFF;

endpackage

// File: rtl/mmio_timer.sv
// Memory-mapped timer: COUNT/CMP/CTRL/STAT registers, match flag and level IRQ.
// Ports: clk, rst (async high), sel, word_ofs (A[15:2]), we, wd -> rd, irq.
module mmio_timer
    import mips_mem_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        sel,
    input  logic [13:0] word_ofs,
    input  logic        we,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        irq
);

    localparam logic [13:0] W_COUNT = TIMER_COUNT_OFS[15:2];
    localparam logic [13:0] W_CMP   = TIMER_CMP_OFS[15:2];
    localparam logic [13:0] W_CTRL  = TIMER_CTRL_OFS[15:2];
    localparam logic [13:0] W_STAT  = TIMER_STAT_OFS[15:2];

    logic [31:0] count_q;
    logic [31:0] cmp_q;
    logic [2:0]  ctrl_q;
    logic        match_q;

    logic is_count, is_cmp, is_ctrl, is_stat;
    logic wr;
    logic en, autoclr, hit;

    assign is_count = (word_ofs == W_COUNT);
    assign is_cmp   = (word_ofs == W_CMP);
    assign is_ctrl  = (word_ofs == W_CTRL);
    assign is_stat  = (word_ofs == W_STAT);
    assign wr       = sel & we;

    assign en      = ctrl_q[EN_BIT];
    assign autoclr = ctrl_q[AUTOCLR_BIT];
    // Compare uses the registered (pre-write) COUNT and CMP.
    assign hit     = en & (count_q == cmp_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            cmp_q   <= CMP_RESET;
            ctrl_q  <= '0;
            match_q <= 1'b0;
        end else begin
            // Software write beats both increment and auto-clear.
            if (wr && is_count)
                count_q <= wd;
            else if (en)
                count_q <= (hit && autoclr) ? 32'd0 : count_q + 32'd1;

            if (wr && is_cmp)
                cmp_q <= wd;

            if (wr && is_ctrl)
                ctrl_q <= wd[2:0];

            // A new match wins over a same-edge W1C.
            if (hit)
                match_q <= 1'b1;
            else if (wr && is_stat && wd[0])
                match_q <= 1'b0;
        end
    end

    always_comb begin
        rd = '0;
        unique case (1'b1)
            is_count: rd = count_q;
            is_cmp:   rd = cmp_q;
            is_ctrl:  rd = {29'd0, ctrl_q};
            is_stat:  rd = {31'd0, match_q};
            default:  rd = '0;
        endcase
    end

    assign irq = match_q & ctrl_q[IRQEN_BIT];

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: word RAM plus memory-mapped timer, combinational reads.
// Ports: CLK, reset (async high), A, WD, WE -> RD, Irq.
module data_mem_responder #(
    parameter int          ADDR_BITS = 8,
    parameter logic [31:0] MMIO_BASE = mips_mem_pkg::MMIO_BASE
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] WD,
    input  logic        WE,
    output logic [31:0] RD,
    output logic        Irq
);

    logic [31:0]          mem [2**ADDR_BITS];
    logic [ADDR_BITS-1:0] idx;
    logic                 mmio_hit;
    logic                 ram_we;
    logic [31:0]          timer_rd;
    logic                 unused_addr;

    // Byte lanes are not decoded; every access is a full word.
    assign unused_addr = ^A[1:0];

    assign mmio_hit = (A[31:16] == MMIO_BASE[31:16]);
    // Upper address bits drop out here, so RAM aliases modulo its size.
    assign idx      = A[ADDR_BITS+1:2];
    assign ram_we   = WE & ~mmio_hit & ~reset;

    always_ff @(posedge CLK) begin
        if (ram_we)
            mem[idx] <= WD;
    end

    mmio_timer u_timer (
        .clk      (CLK),
        .rst      (reset),
        .sel      (mmio_hit),
        .word_ofs (A[15:2]),
        .we       (WE),
        .wd       (WD),
        .rd       (timer_rd),
        .irq      (Irq)
    );

    assign RD = mmio_hit ? timer_rd : mem[idx];

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: vector table plus timer sequences.
module tb_data_mem_responder;

    localparam logic [31:0] T_COUNT = 32'hFFFF_0000;
    localparam logic [31:0] T_CMP   = 32'hFFFF_0004;
    localparam logic [31:0] T_CTRL  = 32'hFFFF_0008;
    localparam logic [31:0] T_STAT  = 32'hFFFF_000C;
    localparam logic [31:0] T_NONE  = 32'hFFFF_0010;

    logic        CLK = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] A = '0;
    logic [31:0] WD = '0;
    logic        WE = 1'b0;
    logic [31:0] RD;
    logic        Irq;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] rd;
        logic        irq;
        string       name;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] wd;
        logic        we;
        logic [31:0] rd;
        logic        irq;
        logic        chk;
        string       name;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[$];

    data_mem_responder #(.ADDR_BITS(8)) dut (
        .CLK   (CLK),
        .reset (reset),
        .A     (A),
        .WD    (WD),
        .WE    (WE),
        .RD    (RD),
        .Irq   (Irq)
    );

    always #5 CLK = ~CLK;

    task automatic expect_now(input logic [31:0] rd, input logic irq,
                              input string name);
        sb.push_back('{rd, irq, name});
    endtask

    task automatic check_one();
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: no expected entry");
        end else begin
            e = sb.pop_front();
            if (RD !== e.rd || Irq !== e.irq) begin
                errors++;
                $display("FAIL %s: RD=%h Irq=%b expected RD=%h Irq=%b",
                         e.name, RD, Irq, e.rd, e.irq);
            end
        end
    endtask

    // Drive one bus cycle; check combinational RD/Irq before the edge.
    task automatic cyc(input logic [31:0] a, input logic [31:0] wd,
                       input logic we, input logic [31:0] rd,
                       input logic irq, input logic chk, input string name);
        A  = a;
        WD = wd;
        WE = we;
        if (chk) expect_now(rd, irq, name);
        #4;
        if (chk) check_one();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        vecs.push_back('{T_COUNT, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, "rst_count"});
        vecs.push_back('{T_CMP, 32'h0, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b1, "rst_cmp"});
        vecs.push_back('{T_CTRL, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, "rst_ctrl"});
        vecs.push_back('{T_STAT, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, "rst_stat"});
        vecs.push_back('{32'h10, 32'hDEAD_BEEF, 1'b1, 32'h0, 1'b0, 1'b0, "st_10"});
        vecs.push_back('{32'h10, 32'h0, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b1, "ld_10"});
        vecs.push_back('{32'h410, 32'h0, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b1, "ld_alias"});
        vecs.push_back('{32'h13, 32'h0, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b1, "ld_unaligned"});
        vecs.push_back('{32'h20, 32'h1, 1'b1, 32'h0, 1'b0, 1'b0, "st_20"});
        vecs.push_back('{32'h20, 32'h2, 1'b1, 32'h1, 1'b0, 1'b1, "rdw_old"});
        vecs.push_back('{32'h20, 32'h0, 1'b0, 32'h2, 1'b0, 1'b1, "rdw_new"});
        vecs.push_back('{T_NONE, 32'h1234_5678, 1'b1, 32'h0, 1'b0, 1'b1, "unmapped_wr"});
        vecs.push_back('{T_NONE, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, "unmapped_rd"});
        vecs.push_back('{32'h10, 32'h0, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b1, "mmio_no_ram"});
        vecs.push_back('{T_COUNT, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, "count_idle"});

        repeat (2) @(posedge CLK);
        #1;
        reset = 1'b0;

        foreach (vecs[i])
            cyc(vecs[i].a, vecs[i].wd, vecs[i].we,
                vecs[i].rd, vecs[i].irq, vecs[i].chk, vecs[i].name);

        // Match with auto-clear and IRQ.
        cyc(T_CMP, 32'd5, 1'b1, 0, 0, 1'b0, "set_cmp");
        cyc(T_CTRL, 32'd7, 1'b1, 0, 0, 1'b0, "set_ctrl");
        for (int k = 0; k < 6; k++)
            cyc(T_COUNT, 0, 1'b0, k, 1'b0, 1'b1, "count_up");
        cyc(T_STAT, 0, 1'b0, 32'd1, 1'b1, 1'b1, "match_stat");
        cyc(T_COUNT, 0, 1'b0, 32'd1, 1'b1, 1'b1, "autoclr_count");
        cyc(T_STAT, 32'd1, 1'b1, 32'd1, 1'b1, 1'b1, "w1c_pre");
        cyc(T_STAT, 0, 1'b0, 32'd0, 1'b0, 1'b1, "w1c_post");
        cyc(T_CTRL, 32'd0, 1'b1, 32'd7, 1'b0, 1'b1, "disable");
        cyc(T_COUNT, 0, 1'b0, 32'd5, 1'b0, 1'b1, "count_hold");
        cyc(T_STAT, 0, 1'b0, 32'd0, 1'b0, 1'b1, "no_match_dis");

        // Wrap without flag, then match at 7 without auto-clear.
        cyc(T_COUNT, 32'hFFFF_FFFE, 1'b1, 0, 0, 1'b0, "set_count");
        cyc(T_CMP, 32'd7, 1'b1, 0, 0, 1'b0, "set_cmp7");
        cyc(T_CTRL, 32'd1, 1'b1, 0, 0, 1'b0, "en_only");
        cyc(T_COUNT, 0, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b1, "pre_wrap0");
        cyc(T_COUNT, 0, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b1, "pre_wrap1");
        cyc(T_COUNT, 0, 1'b0, 32'd0, 1'b0, 1'b1, "wrapped");
        cyc(T_STAT, 0, 1'b0, 32'd0, 1'b0, 1'b1, "wrap_no_flag");
        for (int k = 2; k < 8; k++)
            cyc(T_COUNT, 0, 1'b0, k, 1'b0, 1'b1, "count_to7");
        cyc(T_STAT, 0, 1'b0, 32'd1, 1'b0, 1'b1, "match7_noirq");
        cyc(T_COUNT, 0, 1'b0, 32'd9, 1'b0, 1'b1, "continue_9");

        // Collision priorities.
        cyc(T_CTRL, 32'd0, 1'b1, 0, 0, 1'b0, "dis2");
        cyc(T_STAT, 32'd1, 1'b1, 0, 0, 1'b0, "clr2");
        cyc(T_CMP, 32'd50, 1'b1, 0, 0, 1'b0, "cmp50");
        cyc(T_COUNT, 32'd49, 1'b1, 0, 0, 1'b0, "cnt49");
        cyc(T_CTRL, 32'd1, 1'b1, 0, 0, 1'b0, "en3");
        cyc(T_COUNT, 0, 1'b0, 32'd49, 1'b0, 1'b1, "cnt49_rd");
        cyc(T_COUNT, 32'd100, 1'b1, 32'd50, 1'b0, 1'b1, "coll_wr");
        cyc(T_COUNT, 0, 1'b0, 32'd100, 1'b0, 1'b1, "coll_count");
        cyc(T_STAT, 0, 1'b0, 32'd1, 1'b0, 1'b1, "coll_match");
        cyc(T_CMP, 32'd106, 1'b1, 32'd50, 1'b0, 1'b1, "cmp106");
        for (int k = 103; k < 106; k++)
            cyc(T_COUNT, 0, 1'b0, k, 1'b0, 1'b1, "count_to106");
        cyc(T_STAT, 32'd1, 1'b1, 32'd1, 1'b0, 1'b1, "w1c_vs_set");
        cyc(T_STAT, 0, 1'b0, 32'd1, 1'b0, 1'b1, "set_wins");
        cyc(T_STAT, 32'd1, 1'b1, 32'd1, 1'b0, 1'b1, "w1c_again");
        cyc(T_STAT, 0, 1'b0, 32'd0, 1'b0, 1'b1, "w1c_cleared");

        // Async reset mid-count with Irq asserted.
        cyc(T_CTRL, 32'd0, 1'b1, 0, 0, 1'b0, "dis4");
        cyc(T_COUNT, 32'd41, 1'b1, 0, 0, 1'b0, "cnt41");
        cyc(T_CMP, 32'd41, 1'b1, 0, 0, 1'b0, "cmp41");
        cyc(T_CTRL, 32'd5, 1'b1, 0, 0, 1'b0, "en_irq");
        cyc(T_COUNT, 0, 1'b0, 32'd41, 1'b0, 1'b1, "cnt41_rd");
        A  = T_COUNT;
        WE = 1'b0;
        #1;
        expect_now(32'd42, 1'b1, "pre_reset");
        check_one();
        reset = 1'b1;
        #1;
        expect_now(32'd0, 1'b0, "async_count");
        check_one();
        A = T_CMP;
        #1;
        expect_now(32'hFFFF_FFFF, 1'b0, "async_cmp");
        check_one();
        A = T_CTRL;
        #1;
        expect_now(32'd0, 1'b0, "async_ctrl");
        check_one();
        A  = 32'h10;
        WD = 32'h0;
        WE = 1'b1;
        @(posedge CLK);
        #1;
        WE    = 1'b0;
        reset = 1'b0;
        cyc(32'h10, 0, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b1, "ram_kept");
        cyc(T_NONE, 0, 1'b0, 32'd0, 1'b0, 1'b1, "post_unmapped");
        cyc(T_STAT, 0, 1'b0, 32'd0, 1'b0, 1'b1, "post_stat");

        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_left: %0d entries, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
